// File: rtl/gcnn_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcnn_pool_pkg
// Purpose  : Shared defaults and FSM state encoding for the global max-pool
//            serializer (final graph-pooling stage ahead of the PS writer).
// Contents : DEF_NUM_CH / DEF_CH_W / DEF_DATA_W default sizes, state_e enum.
// Revision : 1.0 - initial release
// ============================================================================
package gcnn_pool_pkg;

  localparam int DEF_NUM_CH = 64;  // feature channels = burst length
  localparam int DEF_CH_W   = 6;   // channel index width
  localparam int DEF_DATA_W = 8;   // unsigned post-ReLU feature width

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

endpackage : gcnn_pool_pkg
`default_nettype wire

// File: rtl/channel_max_regfile.sv
`default_nettype none
// ============================================================================
// Module   : channel_max_regfile
// Purpose  : NUM_CH x DATA_W register file holding per-channel running maxima.
//            Write port performs an unsigned max-update; read port is
//            clear-on-read. The two ports are used in different FSM phases.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            wr_en/wr_ch/wr_val - max-update request (out-of-range ch ignored)
//            rd_ch/rd_data   - combinational read of channel rd_ch
//            clr_en          - zero channel rd_ch at the next edge
// Revision : 1.0 - initial release
// ============================================================================
module channel_max_regfile
  import gcnn_pool_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic              clr_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [NUM_CH];
  logic [DATA_W-1:0] mem_d [NUM_CH];

  // Per-channel decode: a channel index >= NUM_CH matches no entry, so such
  // writes fall through without touching the array.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_comb begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_ch == CH_W'(i)) && (wr_val > mem_q[i])) begin
        mem_d[i] = wr_val;
      end else if (clr_en && (rd_ch == CH_W'(i))) begin
        mem_d[i] = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data = mem_q[rd_ch];

endmodule : channel_max_regfile
`default_nettype wire

// File: rtl/global_max_pool_serializer.sv
`default_nettype none
// ============================================================================
// Module   : global_max_pool_serializer
// Purpose  : Accumulates a per-channel running max over one event frame and,
//            on frame_end, emits the pooled vector as one gap-free burst of
//            NUM_CH beats (addr, data, valid) followed by valid low.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            feat_ch/feat_val/feat_valid     - incoming node feature values
//            frame_end                       - last feature of frame presented
//            addr_out/data_out/valid_out     - registered burst to the writer
//            busy                            - combinational, high off ACCUM
//            overrun                         - sticky input-while-busy flag
// Revision : 1.0 - initial release
// ============================================================================
module global_max_pool_serializer
  import gcnn_pool_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_W-1:0]   feat_ch,
  input  logic [DATA_W-1:0] feat_val,
  input  logic              feat_valid,
  input  logic              frame_end,
  output logic [CH_W-1:0]   addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   k_q, k_d;
  logic [CH_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic              wr_en;
  logic              clr_en;
  logic [DATA_W-1:0] rd_data;

  channel_max_regfile #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_ch   (feat_ch),
    .wr_val  (feat_val),
    .rd_ch   (k_q),
    .clr_en  (clr_en),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;   // addr/data hold their last beat while valid is low
    data_d    = data_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        // A sample coincident with frame_end is written this edge and is
        // therefore visible to the first read in STREAM.
        wr_en = feat_valid;
        if (frame_end) begin
          state_d = ST_STREAM;
          k_d     = '0;
        end
      end
      ST_STREAM: begin
        busy    = 1'b1;
        addr_d  = k_q;
        data_d  = rd_data;
        valid_d = 1'b1;
        clr_en  = 1'b1;   // leaves the array zeroed for the next frame
        if (k_q == LAST_CH) begin
          state_d = ST_GAP;
        end else begin
          k_d = k_q + CH_W'(1);
        end
      end
      ST_GAP: begin
        busy    = 1'b1;
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase

    if (busy && (feat_valid || frame_end)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      k_q       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign addr_out  = addr_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overrun   = overrun_q;

endmodule : global_max_pool_serializer
`default_nettype wire
